// File: rtl/ifm_window_gen_3x3x8.sv
// ---------------------------------------------------------------------------
// ifm_window_gen_3x3x8
//
// Turns a raster-order stream of 8-channel pixels into one zero-padded 3x3
// window per pixel position (stride 1, pad 1, "same" output size). Two line
// buffers hold the previous two image rows. A two-column shift register plus
// the column being read this cycle form the 3x3 neighbourhood. Output is
// push-only: the downstream stage cannot stall it.
//
// Window k (raster order) is produced when input index k+W+1 is accepted. The
// last W+1 windows are produced in FLUSH, which has no input.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   start              one-cycle pulse, starts a frame when idle
//   cfg_width/height   frame size, captured when start is accepted
//   ifm_in_data/valid  pixel beat, channel c at bits [8c+7:8c]
//   ifm_in_ready       high while the frame is still accepting beats
//   ifm_win3x3_0..7    window per channel, tap 3*row+col at bits [8k+7:8k]
//   win_valid          windows are new this cycle
//   frame_done         pulse that arrives with the last window of the frame
//   busy               high from accepted start to the frame_done cycle
// ---------------------------------------------------------------------------
module ifm_window_gen_3x3x8 #(
  parameter int DATA_W    = 8,
  parameter int MAX_WIDTH = 416,
  parameter int DIM_W     = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_W-1:0]      cfg_width,
  input  logic [DIM_W-1:0]      cfg_height,
  input  logic [8*DATA_W-1:0]   ifm_in_data,
  input  logic                  ifm_in_valid,
  output logic                  ifm_in_ready,
  output logic [9*DATA_W-1:0]   ifm_win3x3_0,
  output logic [9*DATA_W-1:0]   ifm_win3x3_1,
  output logic [9*DATA_W-1:0]   ifm_win3x3_2,
  output logic [9*DATA_W-1:0]   ifm_win3x3_3,
  output logic [9*DATA_W-1:0]   ifm_win3x3_4,
  output logic [9*DATA_W-1:0]   ifm_win3x3_5,
  output logic [9*DATA_W-1:0]   ifm_win3x3_6,
  output logic [9*DATA_W-1:0]   ifm_win3x3_7,
  output logic                  win_valid,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int BEAT_W = 8 * DATA_W;
  localparam int WIN_W  = 9 * DATA_W;
  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [DIM_W-1:0]   width_q, width_d, height_q, height_d;
  // Input raster position. In FLUSH it keeps walking past the frame end so
  // the line-buffer reads line up with the windows still to be produced.
  logic [DIM_W-1:0]   col_q, col_d, row_q, row_d;
  // Centre of the next window to be produced.
  logic [DIM_W-1:0]   wx_q, wx_d, wy_q, wy_d;
  // The two older columns of the neighbourhood. Index 0 is the top row.
  logic [BEAT_W-1:0]  lcol_q [3];
  logic [BEAT_W-1:0]  lcol_d [3];
  logic [BEAT_W-1:0]  mcol_q [3];
  logic [BEAT_W-1:0]  mcol_d [3];
  logic [WIN_W-1:0]   win_q [8];
  logic [WIN_W-1:0]   win_d [8];
  logic               win_valid_q, win_valid_d, done_q, done_d;

  // lb0 holds row r-1 and lb1 holds row r-2 relative to the input row r.
  logic [BEAT_W-1:0]  lb0_mem [MAX_WIDTH];
  logic [BEAT_W-1:0]  lb1_mem [MAX_WIDTH];

  logic               xfer, step, emit, last_col, last_in;
  logic [BEAT_W-1:0]  rcol [3];
  logic [BEAT_W-1:0]  tap;
  logic               row_ok [3];
  logic               col_ok [3];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    col_d       = col_q;
    row_d       = row_q;
    wx_d        = wx_q;
    wy_d        = wy_q;
    lcol_d      = lcol_q;
    mcol_d      = mcol_q;
    win_d       = win_q;
    win_valid_d = 1'b0;
    done_d      = 1'b0;
    tap         = '0;

    xfer     = (state_q == RUN) && ifm_in_valid;
    // In FLUSH one window is produced per cycle until the last one is out.
    step     = xfer || ((state_q == FLUSH) && !done_q);
    last_col = (col_q == width_q - ONE);
    last_in  = xfer && last_col && (row_q == height_q - ONE);
    // In RUN, windows start once input index W+1 (row 1, column 1) arrives.
    emit     = (state_q == FLUSH) ? step
             : (xfer && ((row_q > ONE) || ((row_q == ONE) && (col_q != '0))));

    // Column entering the neighbourhood. Past the frame end the bottom row
    // is padding anyway.
    rcol[0] = lb1_mem[col_q];
    rcol[1] = lb0_mem[col_q];
    rcol[2] = (state_q == RUN) ? ifm_in_data : '0;

    // Taps outside the frame are zeroed. This also hides stale line-buffer
    // contents and the previous row's tail after the column wraps.
    row_ok[0] = (wy_q != '0);
    row_ok[1] = 1'b1;
    row_ok[2] = (wy_q != height_q - ONE);
    col_ok[0] = (wx_q != '0);
    col_ok[1] = 1'b1;
    col_ok[2] = (wx_q != width_q - ONE);

    if (step) begin
      lcol_d = mcol_q;
      mcol_d = rcol;
      col_d  = last_col ? '0 : col_q + ONE;
      row_d  = last_col ? row_q + ONE : row_q;
    end

    if (emit) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          tap = (c == 0) ? lcol_q[r] : (c == 1) ? mcol_q[r] : rcol[r];
          if (!(row_ok[r] && col_ok[c])) tap = '0;
          for (int ch = 0; ch < 8; ch++)
            win_d[ch][(3*r+c)*DATA_W +: DATA_W] = tap[ch*DATA_W +: DATA_W];
        end
      end
      win_valid_d = 1'b1;
      done_d      = (wy_q == height_q - ONE) && (wx_q == width_q - ONE);
      wx_d        = (wx_q == width_q - ONE) ? '0 : wx_q + ONE;
      wy_d        = (wx_q == width_q - ONE) ? wy_q + ONE : wy_q;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          width_d  = cfg_width;
          height_d = cfg_height;
          col_d    = '0;
          row_d    = '0;
          wx_d     = '0;
          wy_d     = '0;
        end
      end
      RUN:     if (last_in) state_d = FLUSH;
      // Leave one cycle after the last window so busy covers frame_done.
      FLUSH:   if (done_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      width_q     <= '0;
      height_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      wx_q        <= '0;
      wy_q        <= '0;
      lcol_q      <= '{default: '0};
      mcol_q      <= '{default: '0};
      win_q       <= '{default: '0};
      win_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      col_q       <= col_d;
      row_q       <= row_d;
      wx_q        <= wx_d;
      wy_q        <= wy_d;
      lcol_q      <= lcol_d;
      mcol_q      <= mcol_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      done_q      <= done_d;
    end
  end

  // NOTE: the line buffers have no reset. Every location is written before
  // it is read within a frame, or its taps are masked to zero, so clearing
  // them would only cost a reset fan-out to every RAM bit.
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb1_mem[col_q] <= lb0_mem[col_q];
      lb0_mem[col_q] <= ifm_in_data;
    end
  end

  assign ifm_in_ready = (state_q == RUN);
  assign busy         = (state_q != IDLE);
  assign win_valid    = win_valid_q;
  assign frame_done   = done_q;
  assign ifm_win3x3_0 = win_q[0];
  assign ifm_win3x3_1 = win_q[1];
  assign ifm_win3x3_2 = win_q[2];
  assign ifm_win3x3_3 = win_q[3];
  assign ifm_win3x3_4 = win_q[4];
  assign ifm_win3x3_5 = win_q[5];
  assign ifm_win3x3_6 = win_q[6];
  assign ifm_win3x3_7 = win_q[7];

endmodule

// File: tb/tb_ifm_window_gen_3x3x8.sv
// ---------------------------------------------------------------------------
// tb_ifm_window_gen_3x3x8
//
// Drives frames into ifm_window_gen_3x3x8 and compares every window with a
// padded-convolution window model computed straight from the stored image.
// ---------------------------------------------------------------------------
module tb_ifm_window_gen_3x3x8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [8:0]   cfg_width = '0;
  logic [8:0]   cfg_height = '0;
  logic [63:0]  ifm_in_data = '0;
  logic         ifm_in_valid = 1'b0;
  logic         ifm_in_ready;
  logic [71:0]  ifm_win3x3_0, ifm_win3x3_1, ifm_win3x3_2, ifm_win3x3_3;
  logic [71:0]  ifm_win3x3_4, ifm_win3x3_5, ifm_win3x3_6, ifm_win3x3_7;
  logic         win_valid, frame_done, busy;

  ifm_window_gen_3x3x8 dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_width(cfg_width), .cfg_height(cfg_height),
    .ifm_in_data(ifm_in_data), .ifm_in_valid(ifm_in_valid),
    .ifm_in_ready(ifm_in_ready),
    .ifm_win3x3_0(ifm_win3x3_0), .ifm_win3x3_1(ifm_win3x3_1),
    .ifm_win3x3_2(ifm_win3x3_2), .ifm_win3x3_3(ifm_win3x3_3),
    .ifm_win3x3_4(ifm_win3x3_4), .ifm_win3x3_5(ifm_win3x3_5),
    .ifm_win3x3_6(ifm_win3x3_6), .ifm_win3x3_7(ifm_win3x3_7),
    .win_valid(win_valid), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [63:0]  img [0:2047];
  int           xfer_cyc [0:2047];
  logic [575:0] cap_win [$];
  int           cap_cyc [$];
  bit           cap_rdy [$];
  bit           cap_done [$];

  wire [575:0] win_all = {ifm_win3x3_7, ifm_win3x3_6, ifm_win3x3_5, ifm_win3x3_4,
                          ifm_win3x3_3, ifm_win3x3_2, ifm_win3x3_1, ifm_win3x3_0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (win_valid === 1'b1) begin
      cap_win.push_back(win_all);
      cap_cyc.push_back(cyc);
      cap_rdy.push_back(ifm_in_ready);
      cap_done.push_back(frame_done);
    end
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Window k of a w x h frame: 3x3 neighbourhood of raster pixel k with
  // out-of-frame taps equal to zero.
  function automatic logic [575:0] model_win(input int k, input int w, input int h);
    logic [575:0] r;
    logic [63:0]  v;
    int y, x, yy, xx;
    r = '0;
    y = k / w;
    x = k % w;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        yy = y + dr - 1;
        xx = x + dc - 1;
        v = (yy >= 0 && yy < h && xx >= 0 && xx < w) ? img[yy*w+xx] : 64'd0;
        for (int c = 0; c < 8; c++) r[c*72 + (3*dr+dc)*8 +: 8] = v[c*8 +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [71:0] taps72(input int t [9]);
    logic [71:0] r;
    for (int j = 0; j < 9; j++) r[j*8 +: 8] = 8'(t[j]);
    return r;
  endfunction

  function automatic logic [575:0] get_win(input int k);
    return (k < cap_win.size()) ? cap_win[k] : {576{1'bx}};
  endfunction

  function automatic int get_cyc(input int k);
    return (k < cap_cyc.size()) ? cap_cyc[k] : -1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic clear_capture();
    cap_win.delete();
    cap_cyc.delete();
    cap_rdy.delete();
    cap_done.delete();
  endtask

  task automatic fill_seq(input int n);
    for (int i = 0; i < n; i++)
      for (int c = 0; c < 8; c++) img[i][c*8 +: 8] = 8'(i + 1 + 16*c);
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) img[i] = {$urandom, $urandom};
  endtask

  task automatic start_frame(input int w, input int h);
    cfg_width  = 9'(w);
    cfg_height = 9'(h);
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  // Sends img[0..n-1]; start is also raised while beat start_at is pending.
  task automatic send_beats(input int n, input int gap_pct, input int start_at,
                            output bit ok);
    int i = 0;
    int guard = 0;
    bit xf;
    ok = 1'b1;
    while (i < n) begin
      ifm_in_valid = ($urandom_range(99) >= 32'(gap_pct));
      ifm_in_data  = img[i];
      start        = (i == start_at);
      @(negedge clk);
      xf = ifm_in_valid && (ifm_in_ready === 1'b1);
      if (xf) xfer_cyc[i] = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      if (xf) i++;
      guard++;
      if (guard > 20*n + 100) begin ok = 1'b0; break; end
    end
    ifm_in_valid = 1'b0;
    ifm_in_data  = '0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (frame_done === 1'b1) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (win_valid !== 1'b0) $display("FAIL reset_win_valid got=%b exp=0", win_valid); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got=%b exp=0", frame_done); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else pass_cnt++;
    total_cnt++; if (ifm_in_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", ifm_in_ready); else pass_cnt++;
    total_cnt++; if (win_all !== '0) $display("FAIL reset_windows got=%h exp=0", win_all); else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL idle_busy got=%b exp=0", busy); else pass_cnt++;
  endtask

  // Full check of the 4x4 sequential frame; reused after a mid-frame reset.
  task automatic check_seq_4x4(input string tag, input int d0);
    int e0 [9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
    int e1 [9] = '{0, 0, 0, 0, 17, 18, 0, 21, 22};
    int e5 [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int e15 [9] = '{11, 12, 0, 15, 16, 0, 0, 0, 0};
    logic [575:0] w;
    int dsum;
    total_cnt++; if (cap_win.size() != 16) $display("FAIL %s_count got=%0d exp=16", tag, cap_win.size()); else pass_cnt++;
    total_cnt++; if (get_cyc(0) != xfer_cyc[5] + 1) $display("FAIL %s_first_win_cycle got=%0d exp=%0d", tag, get_cyc(0), xfer_cyc[5] + 1); else pass_cnt++;
    w = get_win(0);
    total_cnt++; if (w[71:0] !== taps72(e0)) $display("FAIL %s_w0_ch0 got=%h exp=%h", tag, w[71:0], taps72(e0)); else pass_cnt++;
    total_cnt++; if (w[143:72] !== taps72(e1)) $display("FAIL %s_w0_ch1 got=%h exp=%h", tag, w[143:72], taps72(e1)); else pass_cnt++;
    w = get_win(5);
    total_cnt++; if (w[71:0] !== taps72(e5)) $display("FAIL %s_w5_ch0 got=%h exp=%h", tag, w[71:0], taps72(e5)); else pass_cnt++;
    w = get_win(15);
    total_cnt++; if (w[71:0] !== taps72(e15)) $display("FAIL %s_w15_ch0 got=%h exp=%h", tag, w[71:0], taps72(e15)); else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      w = get_win(k);
      total_cnt++; if (w !== model_win(k, 4, 4)) $display("FAIL %s_win%0d got=%h exp=%h", tag, k, w, model_win(k, 4, 4)); else pass_cnt++;
    end
    for (int j = 0; j < 5; j++) begin
      total_cnt++;
      if (get_cyc(11+j) != xfer_cyc[15] + 2 + j || (11+j < cap_rdy.size() && cap_rdy[11+j] !== 1'b0))
        $display("FAIL %s_flush%0d cycle got=%0d exp=%0d", tag, j, get_cyc(11+j), xfer_cyc[15] + 2 + j);
      else pass_cnt++;
    end
    dsum = 0;
    foreach (cap_done[i]) dsum += int'(cap_done[i]);
    total_cnt++;
    if (dsum != 1 || cap_done.size() != 16 || cap_done[15] !== 1'b1)
      $display("FAIL %s_done_with_last got=%0d flags exp=1 on window 15", tag, dsum);
    else pass_cnt++;
    total_cnt++; if (done_cnt - d0 != 1) $display("FAIL %s_done_pulses got=%0d exp=1", tag, done_cnt - d0); else pass_cnt++;
  endtask

  task automatic test_basic();
    bit ok;
    int d0;
    clear_capture();
    fill_seq(16);
    d0 = done_cnt;
    start_frame(4, 4);
    total_cnt++; if (busy !== 1'b1) $display("FAIL basic_busy_after_start got=%b exp=1", busy); else pass_cnt++;
    send_beats(16, 0, -1, ok);
    total_cnt++; if (!ok) $display("FAIL basic_send got=timeout exp=16 beats"); else pass_cnt++;
    wait_done(50, ok);
    total_cnt++; if (!ok) $display("FAIL basic_wait_done got=timeout exp=frame_done"); else pass_cnt++;
    check_seq_4x4("basic", d0);
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy_after_done got=%b exp=0", busy); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_wide_random();
    bit ok;
    int bad = 0;
    int edge_bad = 0;
    logic [575:0] w;
    clear_capture();
    fill_rand(1248);
    start_frame(416, 3);
    send_beats(1248, 50, -1, ok);
    total_cnt++; if (!ok) $display("FAIL wide_send got=timeout exp=1248 beats"); else pass_cnt++;
    wait_done(1000, ok);
    total_cnt++; if (!ok) $display("FAIL wide_wait_done got=timeout exp=frame_done"); else pass_cnt++;
    total_cnt++; if (cap_win.size() != 1248) $display("FAIL wide_count got=%0d exp=1248", cap_win.size()); else pass_cnt++;
    for (int k = 0; k < 1248; k++) begin
      w = get_win(k);
      if (w !== model_win(k, 416, 3)) begin
        if (bad < 4) $display("FAIL wide_win%0d got=%h exp=%h", k, w, model_win(k, 416, 3));
        bad++;
      end
      if (k % 416 == 415)
        for (int c = 0; c < 8; c++)
          for (int r = 0; r < 3; r++)
            if (w[c*72 + (3*r+2)*8 +: 8] !== 8'h00) edge_bad++;
    end
    total_cnt++; if (bad != 0) $display("FAIL wide_windows got=%0d bad exp=0", bad); else pass_cnt++;
    total_cnt++; if (edge_bad != 0) $display("FAIL wide_right_edge got=%0d nonzero taps exp=0", edge_bad); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad = 0;
    logic [575:0] w;
    clear_capture();
    for (int i = 0; i < 16; i++) img[i] = '1;
    start_frame(4, 4);
    send_beats(16, 0, -1, ok);
    wait_done(50, ok);
    total_cnt++; if (!ok) $display("FAIL b2b_frame1_done got=timeout exp=frame_done"); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy_on_done got=%b exp=1", busy); else pass_cnt++;
    for (int k = 0; k < 16; k++) if (get_win(k) !== model_win(k, 4, 4)) bad++;
    total_cnt++; if (bad != 0 || cap_win.size() != 16) $display("FAIL b2b_frame1 got=%0d bad of %0d exp=0 of 16", bad, cap_win.size()); else pass_cnt++;
    clear_capture();
    fill_rand(6);
    @(posedge clk); #1;
    cfg_width  = 9'd3;
    cfg_height = 9'd2;
    start      = 1'b1;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("FAIL b2b_gap_busy got=%b exp=0", busy); else pass_cnt++;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_busy_restart got=%b exp=1", busy); else pass_cnt++;
    @(posedge clk); #1;
    send_beats(6, 25, -1, ok);
    wait_done(50, ok);
    total_cnt++; if (!ok) $display("FAIL b2b_frame2_done got=timeout exp=frame_done"); else pass_cnt++;
    total_cnt++; if (cap_win.size() != 6) $display("FAIL b2b_frame2_count got=%0d exp=6", cap_win.size()); else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      w = get_win(k);
      total_cnt++; if (w !== model_win(k, 3, 2)) $display("FAIL b2b_f2_win%0d got=%h exp=%h", k, w, model_win(k, 3, 2)); else pass_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int d0;
    clear_capture();
    fill_seq(16);
    d0 = done_cnt;
    start_frame(4, 4);
    send_beats(7, 0, -1, ok);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (win_all !== '0) $display("FAIL rstmid_windows got=%h exp=0", win_all); else pass_cnt++;
    total_cnt++;
    if (win_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 || ifm_in_ready !== 1'b0)
      $display("FAIL rstmid_ctrl got=%b%b%b%b exp=0000", win_valid, frame_done, busy, ifm_in_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    total_cnt++; if (done_cnt != d0 || busy !== 1'b0) $display("FAIL rstmid_no_done got=%0d pulses busy=%b exp=0 pulses busy=0", done_cnt - d0, busy); else pass_cnt++;
    clear_capture();
    d0 = done_cnt;
    start_frame(4, 4);
    send_beats(16, 0, -1, ok);
    wait_done(50, ok);
    total_cnt++; if (!ok) $display("FAIL rstmid_rerun_done got=timeout exp=frame_done"); else pass_cnt++;
    check_seq_4x4("rerun", d0);
    @(posedge clk); #1;
  endtask

  task automatic test_start_ignored();
    bit ok;
    int d0;
    logic [575:0] w;
    clear_capture();
    fill_rand(16);
    d0 = done_cnt;
    start_frame(4, 4);
    send_beats(16, 30, 5, ok);
    // FLUSH is active now; this start carries a different size.
    cfg_width  = 9'd2;
    cfg_height = 9'd2;
    start_frame(2, 2);
    wait_done(50, ok);
    total_cnt++; if (!ok) $display("FAIL ignore_wait_done got=timeout exp=frame_done"); else pass_cnt++;
    total_cnt++; if (cap_win.size() != 16) $display("FAIL ignore_count got=%0d exp=16", cap_win.size()); else pass_cnt++;
    total_cnt++; if (get_cyc(15) != xfer_cyc[15] + 6) $display("FAIL ignore_done_cycle got=%0d exp=%0d", get_cyc(15), xfer_cyc[15] + 6); else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      w = get_win(k);
      total_cnt++; if (w !== model_win(k, 4, 4)) $display("FAIL ignore_win%0d got=%h exp=%h", k, w, model_win(k, 4, 4)); else pass_cnt++;
    end
    repeat (5) @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b0 || done_cnt - d0 != 1) $display("FAIL ignore_no_restart got=busy %b pulses %0d exp=busy 0 pulses 1", busy, done_cnt - d0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide_random();
    test_back_to_back();
    test_reset_mid_frame();
    test_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ifm_window_gen_3x3x8.md
Name: ifm_window_gen_3x3x8

Overview:
Upstream stage of the 8-input-channel 3x3 convolution kernel array. It accepts a raster-order pixel stream, 8 channels × 8 bit per beat, and buffers two image lines. It emits one zero-padded 3x3 window per pixel position on ifm_win3x3_0..7 (stride 1, pad 1, "same" output size). Output is push-only: the downstream kernel has no backpressure.

Parameters:
DATA_W, 8, bits per pixel per channel
MAX_WIDTH, 416, maximum supported frame width (line buffer depth)
DIM_W, 9, width of cfg_width/cfg_height and internal row/column counters

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
start  input  1  one-cycle pulse; begins a frame when idle
cfg_width  input  DIM_W  frame width W, legal 2..MAX_WIDTH; latched on accepted start
cfg_height  input  DIM_W  frame height H, legal >=2; latched on accepted start
ifm_in_data  input  8*DATA_W  pixel beat; bits [8c+7:8c] = channel c
ifm_in_valid  input  1  ifm_in_data valid
ifm_in_ready  output  1  block accepts a beat; transfer = valid & ready
ifm_win3x3_0 .. ifm_win3x3_7  output  72 each  window for channel c; tap k=3r+col at bits [8k+7:8k], r=0 top row, col=0 left column, tap 4 = centre
win_valid  output  1  windows valid this cycle
frame_done  output  1  one-cycle pulse, coincident with the last window of the frame
busy  output  1  high from accepted start until the cycle after frame_done

Behaviour:
- Reset: all outputs 0 (windows, win_valid, frame_done, busy, ifm_in_ready). FSM goes to IDLE and counters clear. Line-buffer contents are don't-care.
- FSM states: IDLE, RUN, FLUSH.
- IDLE -> RUN on start. Latch W and H; clear counters; busy=1 from the next cycle. start in RUN or FLUSH is ignored.
- RUN: ifm_in_ready=1. Each transfer writes the beat into the line buffer and shift registers and advances input raster index i (0..N-1, N=W*H).
- RUN -> FLUSH on the transfer of i=N-1. ifm_in_ready=0 from the next cycle.
- Window k, centred at (y,x) in raster order, is produced when input index k+W+1 is accepted. win_valid is registered, asserted the cycle after that transfer. So window 0 appears one cycle after pixel index W+1 (row 1, col 1) is accepted.
- Input gaps (valid=0) produce gaps in win_valid. Window order is strictly raster; no window is dropped or duplicated.
- FLUSH: the remaining W+1 windows (k=N-W-1..N-1) are emitted on consecutive cycles with no input. frame_done=1 with window N-1. Next cycle: IDLE, busy=0.
- Padding: any tap whose row or column falls outside [0,H-1]×[0,W-1] is driven 0. This covers top/bottom rows, left/right columns and all corners. No data from the previous row's end or the previous frame may leak into a window.
- Window outputs hold their last value while win_valid=0.
- Line buffers: two MAX_WIDTH×64-bit memories, addressed by column counter 0..W-1. The column counter wraps at W-1 and the row counter increments at the wrap.
- Reset mid-frame: immediate abort. Outputs go to 0 and the FSM returns to IDLE; no frame_done. The next start runs a clean frame.
- Out-of-range cfg values are not checked; behaviour is undefined.

Test Plan:
- W=4, H=4, ch0 pixel = raster index+1, ch c = ch0+16c. First win_valid one cycle after the 6th transfer. ifm_win3x3_0 taps 0..8 = 0,0,0,0,1,2,0,5,6. ifm_win3x3_1 taps 0..8 = 0,0,0,0,17,18,0,21,22.
- Same frame, full check: 16 windows in raster order. Window 5 (y=1,x=1) taps = 1,2,3,5,6,7,9,10,11. Window 15 taps = 11,12,0,15,16,0,0,0,0. FLUSH emits 5 windows on back-to-back cycles. frame_done coincides with window 15. ifm_in_ready=0 during FLUSH.
- W=416, H=3, random data, ifm_in_valid randomly deasserted 50% of cycles. Exactly 1248 windows, matching a golden padded-conv window model, including the right-edge column x=415 zeroed.
- Two back-to-back frames (4×4 then 3×2, all pixels 0xFF in frame 1). All frame-2 padding taps are 0, with no 0xFF leakage. busy drops for exactly one cycle between frames.
- Assert rst for one cycle after 7 transfers of a 4×4 frame. All outputs read 0 next cycle, no frame_done. A following start plus full frame reproduces scenario 1 exactly.
- start pulsed during RUN and during FLUSH: ignored. Window count and frame_done timing are unchanged.
